// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge: APB slave front end for the register blocks.
// Turns each APB transfer into a single register-bus request. The request
// stays up until a register acknowledges it or a bounded wait expires.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   i_psel .. i_pwdata           APB request inputs
//   o_pready/o_prdata/o_pslverr  APB completion (one-cycle pulse)
//   o_register_*                 register-bus request (valid/addr/write/data/mask)
//   i_register_*                 OR-reduced register response
module rggen_apb_bridge #(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_psel,
    input  logic                       i_penable,
    input  logic [ADDRESS_WIDTH-1:0]   i_paddr,
    input  logic                       i_pwrite,
    input  logic [DATA_WIDTH/8-1:0]    i_pstrb,
    input  logic [DATA_WIDTH-1:0]      i_pwdata,
    output logic                       o_pready,
    output logic [DATA_WIDTH-1:0]      o_prdata,
    output logic                       o_pslverr,
    output logic                       o_register_valid,
    output logic [ADDRESS_WIDTH-1:0]   o_register_address,
    output logic                       o_register_write,
    output logic [DATA_WIDTH-1:0]      o_register_write_data,
    output logic [DATA_WIDTH-1:0]      o_register_strobe,
    input  logic                       i_register_ready,
    input  logic                       i_register_error,
    input  logic [DATA_WIDTH-1:0]      i_register_read_data
);

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned LSB_WIDTH   = $clog2(STRB_WIDTH);
    localparam int unsigned COUNT_WIDTH = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    // Clears the byte-offset bits so requests are always word aligned.
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK =
        ~ADDRESS_WIDTH'((1 << LSB_WIDTH) - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST =
        COUNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESPONSE = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [COUNT_WIDTH-1:0]     count_q, count_d;
    logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
    logic                       write_q, write_d;
    logic [DATA_WIDTH-1:0]      write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0]      strobe_q, strobe_d;
    logic                       valid_q, valid_d;
    logic                       pready_q, pready_d;
    logic [DATA_WIDTH-1:0]      prdata_q, prdata_d;
    logic                       pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]      strobe_expanded_c;
    logic                       timeout_c;

    // Byte strobes widened into a bitwise write mask.
    always_comb begin
        strobe_expanded_c = '0;
        for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
            strobe_expanded_c[i*8 +: 8] = {8{i_pstrb[i]}};
        end
    end

    assign timeout_c = TIMEOUT_EN && (count_q == COUNT_LAST);

    // Next-state and registered-output logic; completion outputs default to 0
    // so they are a single-cycle pulse.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        address_d    = address_q;
        write_d      = write_q;
        write_data_d = write_data_q;
        strobe_d     = strobe_q;
        valid_d      = 1'b0;
        pready_d     = 1'b0;
        prdata_d     = '0;
        pslverr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    state_d      = ACCESS;
                    valid_d      = 1'b1;
                    count_d      = '0;
                    address_d    = i_paddr & ADDRESS_MASK;
                    write_d      = i_pwrite;
                    write_data_d = i_pwdata;
                    strobe_d     = i_pwrite ? strobe_expanded_c : '0;
                end
            end
            ACCESS: begin
                valid_d = 1'b1;
                // Saturate so a disabled timeout can wait forever without wrapping.
                if (count_q != '1) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
                // Ready has priority over an expiring timeout.
                if (i_register_ready) begin
                    state_d   = RESPONSE;
                    valid_d   = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = i_register_error;
                    prdata_d  = write_q ? '0 : i_register_read_data;
                end else if (timeout_c) begin
                    state_d   = RESPONSE;
                    valid_d   = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end
            end
            RESPONSE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            address_q    <= '0;
            write_q      <= 1'b0;
            write_data_q <= '0;
            strobe_q     <= '0;
            valid_q      <= 1'b0;
            pready_q     <= 1'b0;
            prdata_q     <= '0;
            pslverr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            address_q    <= address_d;
            write_q      <= write_d;
            write_data_q <= write_data_d;
            strobe_q     <= strobe_d;
            valid_q      <= valid_d;
            pready_q     <= pready_d;
            prdata_q     <= prdata_d;
            pslverr_q    <= pslverr_d;
        end
    end

    assign o_pready              = pready_q;
    assign o_prdata              = prdata_q;
    assign o_pslverr             = pslverr_q;
    assign o_register_valid      = valid_q;
    assign o_register_address    = address_q;
    assign o_register_write      = write_q;
    assign o_register_write_data = write_data_q;
    assign o_register_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Testbench for rggen_apb_bridge: APB master + register responder driving
// directed and random transfers; a per-cycle expectation table built from
// transfer-level rules is compared against the DUT outputs every cycle.
module tb_rggen_apb_bridge;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 16;
    localparam int          MAXC = 8192;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW/8-1:0] pstrb;
    logic [DW-1:0]   pwdata;
    logic            pready, pslverr;
    logic [DW-1:0]   prdata;
    logic            reg_valid, reg_write;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_wdata, reg_strobe;
    logic            reg_ready, reg_error;
    logic [DW-1:0]   reg_rdata;

    rggen_apb_bridge #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_psel                (psel),
        .i_penable             (penable),
        .i_paddr               (paddr),
        .i_pwrite              (pwrite),
        .i_pstrb               (pstrb),
        .i_pwdata              (pwdata),
        .o_pready              (pready),
        .o_prdata              (prdata),
        .o_pslverr             (pslverr),
        .o_register_valid      (reg_valid),
        .o_register_address    (reg_addr),
        .o_register_write      (reg_write),
        .o_register_write_data (reg_wdata),
        .o_register_strobe     (reg_strobe),
        .i_register_ready      (reg_ready),
        .i_register_error      (reg_error),
        .i_register_read_data  (reg_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle index (0 unless a transfer sets them).
    bit          exp_valid  [MAXC];
    bit          exp_pready [MAXC];
    bit          exp_pslverr[MAXC];
    bit [31:0]   exp_prdata [MAXC];
    bit [15:0]   exp_addr   [MAXC];
    bit          exp_write  [MAXC];
    bit [31:0]   exp_wdata  [MAXC];
    bit [31:0]   exp_strobe [MAXC];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expectation table.
    always @(negedge clk) begin : cmp
        int c;
        c = cyc;
        if (c < MAXC) begin
            chk("valid",   32'(reg_valid), 32'(exp_valid[c]));
            chk("pready",  32'(pready),    32'(exp_pready[c]));
            chk("pslverr", 32'(pslverr),   32'(exp_pslverr[c]));
            chk("prdata",  prdata,         exp_prdata[c]);
            if (exp_valid[c]) begin
                chk("address", 32'(reg_addr),  32'(exp_addr[c]));
                chk("write",   32'(reg_write), 32'(exp_write[c]));
                chk("wdata",   reg_wdata,      exp_wdata[c]);
                chk("strobe",  reg_strobe,     exp_strobe[c]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        tick();
        psel      = 1'b0;
        penable   = 1'b0;
        paddr     = AW'($urandom);
        pwrite    = 1'($urandom);
        reg_ready = 1'($urandom);
        reg_error = 1'($urandom);
        reg_rdata = $urandom;
    endtask

    // One APB transfer. ready_at = ACCESS cycle (1-based) on which the register
    // acknowledges; 0 or beyond TO means it never does in time.
    task automatic do_xfer(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                           input logic [3:0] sb, input int ready_at, input bit err,
                           input logic [31:0] rd, output int nvalid, output int roff,
                           output logic [31:0] gaddr, output logic [31:0] gstrb,
                           output logic [31:0] gprdata, output logic [31:0] gerr);
        int s;
        int n;
        bit acked;
        logic [31:0] mask;
        tick();
        s = cyc;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd; pstrb = sb;
        reg_ready = 1'($urandom); reg_error = 1'($urandom); reg_rdata = $urandom;
        acked = (ready_at >= 1) && (ready_at <= int'(TO));
        n = acked ? ready_at : int'(TO);
        mask = '0;
        if (wr) for (int i = 0; i < 4; i++) if (sb[i]) mask = mask | (32'hFF << (8 * i));
        if (s + n + 1 < MAXC) begin
            for (int c = s + 1; c <= s + n; c++) begin
                exp_valid[c]  = 1'b1;
                exp_addr[c]   = a & 16'hFFFC;
                exp_write[c]  = wr;
                exp_wdata[c]  = wd;
                exp_strobe[c] = mask;
            end
            exp_pready[s+n+1]  = 1'b1;
            exp_pslverr[s+n+1] = acked ? err : 1'b1;
            exp_prdata[s+n+1]  = (acked && !wr) ? rd : 32'h0;
        end
        nvalid = 0; roff = 0; gaddr = '0; gstrb = '0; gprdata = '0; gerr = '0;
        for (int k = 1; k <= n + 1; k++) begin
            tick();
            if (reg_valid) nvalid++;
            if (k == 1) begin gaddr = 32'(reg_addr); gstrb = reg_strobe; end
            if (pready && roff == 0) begin roff = k; gprdata = prdata; gerr = 32'(pslverr); end
            // Master-side changes after capture must be ignored.
            penable = 1'b1; paddr = AW'($urandom); pwdata = $urandom;
            pstrb = 4'($urandom); pwrite = 1'($urandom);
            if (k == ready_at) begin
                reg_ready = 1'b1; reg_error = err; reg_rdata = rd;
            end else begin
                reg_ready = (k == n + 1) ? 1'($urandom) : 1'b0;
                reg_error = 1'($urandom); reg_rdata = $urandom;
            end
        end
    endtask

    int          nv, ro;
    logic [31:0] ga, gs, gp, ge;

    initial begin
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pstrb = '0; pwdata = '0;
        reg_ready = 0; reg_error = 0; reg_rdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) idle_cycle();
        chk("reset_valid",   32'(reg_valid),  32'h0);
        chk("reset_pready",  32'(pready),     32'h0);
        chk("reset_prdata",  prdata,          32'h0);
        chk("reset_address", 32'(reg_addr),   32'h0);
        chk("reset_strobe",  reg_strobe,      32'h0);
        rst_n = 1'b1;
        idle_cycle();

        // Write, immediate ready.
        do_xfer(1'b1, 16'h0012, 32'hA5A5_1234, 4'b0011, 1, 1'b0, 32'h0, nv, ro, ga, gs, gp, ge);
        chk("wr_nvalid",  32'(nv), 32'd1);
        chk("wr_latency", 32'(ro), 32'd2);
        chk("wr_addr",    ga,      32'h0000_0010);
        chk("wr_strobe",  gs,      32'h0000_FFFF);
        chk("wr_pslverr", ge,      32'h0);
        idle_cycle();

        // Read with a 3-cycle stall.
        do_xfer(1'b0, 16'h0104, 32'h1111_2222, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, nv, ro, ga, gs, gp, ge);
        chk("rd_nvalid",  32'(nv), 32'd3);
        chk("rd_latency", 32'(ro), 32'd4);
        chk("rd_prdata",  gp,      32'hDEAD_BEEF);
        chk("rd_strobe",  gs,      32'h0);

        // Timeout with no acknowledge, then a normal transfer.
        do_xfer(1'b0, 16'h0200, 32'h0, 4'h0, 0, 1'b0, 32'h0, nv, ro, ga, gs, gp, ge);
        chk("to_nvalid",  32'(nv), 32'd16);
        chk("to_latency", 32'(ro), 32'd17);
        chk("to_pslverr", ge,      32'h1);
        chk("to_prdata",  gp,      32'h0);
        do_xfer(1'b0, 16'h0208, 32'h0, 4'h0, 2, 1'b0, 32'h0BAD_F00D, nv, ro, ga, gs, gp, ge);
        chk("post_to_prdata",  gp, 32'h0BAD_F00D);
        chk("post_to_pslverr", ge, 32'h0);

        // Error on a write; ready+error on the final allowed cycle.
        do_xfer(1'b1, 16'h0033, 32'hCAFE_0001, 4'b1000, 1, 1'b1, 32'hFFFF_FFFF, nv, ro, ga, gs, gp, ge);
        chk("werr_pslverr", ge, 32'h1);
        chk("werr_prdata",  gp, 32'h0);
        chk("werr_strobe",  gs, 32'hFF00_0000);
        do_xfer(1'b0, 16'h0040, 32'h0, 4'h0, 16, 1'b1, 32'h1234_5678, nv, ro, ga, gs, gp, ge);
        chk("lastcyc_nvalid",  32'(nv), 32'd16);
        chk("lastcyc_prdata",  gp,      32'h1234_5678);
        chk("lastcyc_pslverr", ge,      32'h1);

        // Back-to-back read / write / read.
        do_xfer(1'b0, 16'h0010, 32'h0, 4'h0, 1, 1'b0, 32'h0000_00A1, nv, ro, ga, gs, gp, ge);
        chk("b2b0_latency", 32'(ro), 32'd2);
        do_xfer(1'b1, 16'h0014, 32'h5555_AAAA, 4'hF, 1, 1'b0, 32'h0, nv, ro, ga, gs, gp, ge);
        chk("b2b1_latency", 32'(ro), 32'd2);
        chk("b2b1_strobe",  gs,      32'hFFFF_FFFF);
        do_xfer(1'b0, 16'h0018, 32'h0, 4'h0, 1, 1'b0, 32'h0000_00A3, nv, ro, ga, gs, gp, ge);
        chk("b2b2_prdata",  gp,      32'h0000_00A3);

        // Asynchronous reset in the middle of ACCESS.
        begin
            int s;
            tick();
            s = cyc;
            psel = 1'b1; penable = 1'b0; paddr = 16'h0050; pwrite = 1'b0;
            reg_ready = 1'b0;
            exp_valid[s+1] = 1'b1; exp_addr[s+1] = 16'h0050;
            exp_write[s+1] = 1'b0; exp_wdata[s+1] = pwdata; exp_strobe[s+1] = 32'h0;
            tick(); penable = 1'b1;
            tick();
            #2 rst_n = 1'b0;
            #1;
            chk("rst_valid_drop",  32'(reg_valid), 32'h0);
            chk("rst_pready_drop", 32'(pready),    32'h0);
            psel = 1'b0; penable = 1'b0;
            reg_ready = 1'b1; reg_error = 1'b1; reg_rdata = 32'hFFFF_0000;
            tick(); tick();
            rst_n = 1'b1;
            tick(); tick(); tick();
            reg_ready = 1'b0;
        end
        do_xfer(1'b0, 16'h0060, 32'h0, 4'h0, 2, 1'b0, 32'h7777_8888, nv, ro, ga, gs, gp, ge);
        chk("rst_fresh_prdata",  gp,      32'h7777_8888);
        chk("rst_fresh_latency", 32'(ro), 32'd3);

        // Random transfers.
        for (int t = 0; t < 150 && cyc < MAXC - 60; t++) begin
            int r;
            int ra;
            r = int'($urandom_range(0, 9));
            if (r <= 5)      ra = int'($urandom_range(1, 4));
            else if (r == 6) ra = 0;
            else if (r == 7) ra = 16;
            else if (r == 8) ra = 15;
            else             ra = 17;
            do_xfer(1'($urandom), AW'($urandom), $urandom, 4'($urandom), ra,
                    ($urandom_range(0, 3) == 0), $urandom, nv, ro, ga, gs, gp, ge);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        repeat (3) idle_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
